// File: rtl/ct_rtu_ptr_expand.sv
// Circular queue pointer {wrap, index} with a registered one-hot of the current entry
// and a rotated window of WIN consecutive one-hot entries for downstream entry logic.
module ct_rtu_ptr_expand #(
  parameter int PTR_W = 3,
  parameter int INC_W = 2,
  parameter int WIN   = 4
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  input  logic                         x_flush,
  input  logic [PTR_W:0]               x_flush_ptr,
  input  logic                         x_inc_vld,
  input  logic [INC_W-1:0]             x_inc_num,
  output logic [PTR_W:0]               x_ptr,
  output logic [(1<<PTR_W)-1:0]        x_ptr_expand,
  output logic [WIN*(1<<PTR_W)-1:0]    x_win_expand,
  output logic [WIN-1:0]               x_win_wrap
);

  localparam int ENTRY = 1 << PTR_W;
  localparam logic [PTR_W:0] ENTRY_V = (PTR_W+1)'(ENTRY);

  if (((1 << INC_W) - 1) > ENTRY) begin : g_bad_inc_w
    $error("ct_rtu_ptr_expand: max step 2^INC_W-1 exceeds queue depth");
  end
  if ((WIN < 1) || (WIN > ENTRY)) begin : g_bad_win
    $error("ct_rtu_ptr_expand: WIN must lie in 1..ENTRY");
  end

  function automatic logic [ENTRY-1:0] f_onehot(input logic [PTR_W-1:0] idx);
    logic [ENTRY-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [PTR_W:0]     r_ptr;
  logic [ENTRY-1:0]   r_ptr_expand;
  logic [PTR_W:0]     w_next_ptr;
  logic [ENTRY-1:0]   w_next_expand;

  // Next pointer: flush outranks increment; the modulo-2^(PTR_W+1) add toggles wrap on carry.
  always_comb begin
    w_next_ptr = r_ptr;
    if (x_flush) begin
      w_next_ptr = x_flush_ptr;
    end else if (x_inc_vld) begin
      w_next_ptr = r_ptr + {{(PTR_W+1-INC_W){1'b0}}, x_inc_num};
    end else begin
      w_next_ptr = r_ptr;
    end
    w_next_expand = f_onehot(w_next_ptr[PTR_W-1:0]);
  end

  // Pointer and its one-hot live in separate flops so the one-hot never waits on a decoder.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_ptr        <= '0;
      r_ptr_expand <= {{(ENTRY-1){1'b0}}, 1'b1};
    end else begin
      r_ptr        <= w_next_ptr;
      r_ptr_expand <= w_next_expand;
    end
  end

  assign x_ptr        = r_ptr;
  assign x_ptr_expand = r_ptr_expand;

  for (genvar k = 0; k < WIN; k++) begin : g_win
    localparam logic [PTR_W:0] K_OFF = (PTR_W+1)'(k);
    // Wrap of pointer+k: carry out of index+k flips the stored wrap bit.
    assign x_win_wrap[k] = r_ptr[PTR_W] ^
                           (({1'b0, r_ptr[PTR_W-1:0]} + K_OFF) >= ENTRY_V);
    for (genvar j = 0; j < ENTRY; j++) begin : g_rot
      assign x_win_expand[k*ENTRY + ((j + k) % ENTRY)] = r_ptr_expand[j];
    end
  end

endmodule

// File: tb/tb_ct_rtu_ptr_expand.sv
// Self-checking bench for ct_rtu_ptr_expand: directed corner cases plus random
// flush/increment traffic compared against an arithmetic pointer model.
module tb_ct_rtu_ptr_expand;

  localparam int PTR_W = 3;
  localparam int INC_W = 2;
  localparam int WIN   = 4;
  localparam int ENTRY = 1 << PTR_W;
  localparam int MODV  = 2 * ENTRY;

  logic                     clk;
  logic                     rst_b;
  logic                     flush;
  logic [PTR_W:0]           flush_ptr;
  logic                     inc_vld;
  logic [INC_W-1:0]         inc_num;
  logic [PTR_W:0]           ptr;
  logic [ENTRY-1:0]         ptr_exp;
  logic [WIN*ENTRY-1:0]     win_exp;
  logic [WIN-1:0]           win_wrap;

  int n_cmp;
  int n_bad;
  int m_ptr;

  ct_rtu_ptr_expand #(.PTR_W(PTR_W), .INC_W(INC_W), .WIN(WIN)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .x_flush        (flush),
    .x_flush_ptr    (flush_ptr),
    .x_inc_vld      (inc_vld),
    .x_inc_num      (inc_num),
    .x_ptr          (ptr),
    .x_ptr_expand   (ptr_exp),
    .x_win_expand   (win_exp),
    .x_win_wrap     (win_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_onehot(input int p);
    logic [255:0] one;
    one = 256'd1;
    return one << (p % ENTRY);
  endfunction

  function automatic logic [255:0] exp_window(input int p);
    logic [255:0] one;
    logic [255:0] v;
    one = 256'd1;
    v   = 256'd0;
    for (int k = 0; k < WIN; k++) v = v | (one << (k * ENTRY + ((p + k) % ENTRY)));
    return v;
  endfunction

  function automatic logic [255:0] exp_wraps(input int p);
    logic [255:0] v;
    v = 256'd0;
    for (int k = 0; k < WIN; k++) v[k] = (((p + k) / ENTRY) % 2) == 1;
    return v;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".ptr"},  256'(ptr),      256'(m_ptr));
    chk({tag, ".exp"},  256'(ptr_exp),  exp_onehot(m_ptr));
    chk({tag, ".win"},  256'(win_exp),  exp_window(m_ptr));
    chk({tag, ".wrap"}, 256'(win_wrap), exp_wraps(m_ptr));
  endtask

  // Drive one cycle of stimulus, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic f, input int fp, input logic v, input int n);
    flush     = f;
    flush_ptr = (PTR_W+1)'(fp);
    inc_vld   = v;
    inc_num   = INC_W'(n);
    @(posedge clk);
    #1;
    if (f) m_ptr = fp % MODV;
    else if (v) m_ptr = (m_ptr + n) % MODV;
    flush   = 1'b0;
    inc_vld = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_ptr = 0;
    rst_b = 1'b0;
    flush = 1'b0;
    flush_ptr = '0;
    inc_vld = 1'b0;
    inc_num = '0;
    #12;
    chk("rst.ptr",  256'(ptr),      256'(4'b0000));
    chk("rst.exp",  256'(ptr_exp),  256'(8'h01));
    chk("rst.win",  256'(win_exp),  256'({8'h08, 8'h04, 8'h02, 8'h01}));
    chk("rst.wrap", 256'(win_wrap), 256'(4'b0000));
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 0, 1'b0, 0);
      chk("idle.ptr", 256'(ptr), 256'(4'b0000));
      chk("idle.exp", 256'(ptr_exp), 256'(8'h01));
    end

    step(1'b1, 6, 1'b0, 0);
    chk("straddle.win",  256'(win_exp),  256'({8'h02, 8'h01, 8'h80, 8'h40}));
    chk("straddle.wrap", 256'(win_wrap), 256'(4'b1100));
    step(1'b0, 0, 1'b1, 3);
    chk("wrap1.ptr", 256'(ptr), 256'(4'b1001));
    chk("wrap1.exp", 256'(ptr_exp), 256'(8'h02));
    step(1'b0, 0, 1'b1, 3);
    step(1'b0, 0, 1'b1, 3);
    chk("wrap2.ptr", 256'(ptr), 256'(4'b1111));
    step(1'b0, 0, 1'b1, 3);
    chk("wrap3.ptr", 256'(ptr), 256'(4'b0010));
    check_model("wrap3");

    step(1'b1, 11, 1'b1, 2);
    chk("flushwin.ptr", 256'(ptr), 256'(4'b1011));
    chk("flushwin.exp", 256'(ptr_exp), 256'(8'h08));
    step(1'b0, 0, 1'b1, 0);
    chk("inc0.ptr", 256'(ptr), 256'(4'b1011));
    check_model("inc0");

    step(1'b1, 13, 1'b0, 0);
    chk("pre_arst.ptr", 256'(ptr), 256'(4'b1101));
    #2;
    rst_b = 1'b0;
    #1;
    m_ptr = 0;
    chk("arst.ptr",  256'(ptr),      256'(4'b0000));
    chk("arst.exp",  256'(ptr_exp),  256'(8'h01));
    chk("arst.win",  256'(win_exp),  256'({8'h08, 8'h04, 8'h02, 8'h01}));
    chk("arst.wrap", 256'(win_wrap), 256'(4'b0000));
    @(negedge clk);
    rst_b = 1'b1;
    step(1'b0, 0, 1'b1, 1);
    chk("post_arst.ptr", 256'(ptr), 256'(4'b0001));

    for (int i = 0; i < 400; i++) begin
      logic f;
      logic v;
      f = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(f, $urandom_range(0, MODV - 1), v, $urandom_range(0, (1 << INC_W) - 1));
      check_model("rnd");
      chk("rnd.onehot", 256'($countones(ptr_exp)), 256'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
